seg_scan_scheduler: RTL and testbench
=====================================

// Module: seg_scan_scheduler
// PURPOSE
//  Time-multiplexes the DataPath's single shared 7-segment bus across 4 digit
//  enables. It scans the digits, inserts a ghost-free blanking gap between
//  digits and latches new 16-bit display values only at frame boundaries, so a
//  frame never shows a mix of old and new digits. It sits between the DataPath
//  value source (register selected by the toggle switches) and the board pins.
// PARAMETERS
//  REFRESH_DIV   50000  clk cycles each digit is driven (SHOW slot), >=2
//  BLANK_CYCLES  1000   clk cycles all digits are off between slots, >=1
// PORTS
//  clk              in   1   system clock, all logic on rising edge
//  rst              in   1   synchronous reset, ACTIVE-LOW
//  enable           in   1   1 = scan; 0 = all digits off, FSM held in IDLE
//  value_in         in   16  candidate display value, 4 hex nibbles
//  load_req         in   1   level request to latch value_in
//  load_ack         out  1   1-cycle pulse: value_in captured this cycle
//  lz_suppress      in   1   1 = blank leading zero digits
//  enabler_segment  out  4   digit enables, active-low, bit i = digit i (0 = LSD)
//  sevent           out  7   segments {g,f,e,d,c,b,a}, active-low
//  frame_start      out  1   1-cycle pulse when digit 0 SHOW slot begins
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): state=IDLE, idx=0, shadow=16'h0000,
//    slot counter=0, enabler_segment=4'b1111, sevent=7'b1111111, load_ack=0,
//    frame_start=0. All outputs are registered.
//  - States: IDLE -> SHOW (enable==1, idx=0); SHOW -> BLANK after REFRESH_DIV
//    cycles; BLANK -> SHOW after BLANK_CYCLES cycles, idx=(idx+1) mod 4
//    (3 wraps to 0). Any state -> IDLE when enable==0, within 1 cycle, with
//    idx=0 and outputs forced to all-off. shadow keeps its value.
//  - Slot counter: width $clog2(max(REFRESH_DIV,BLANK_CYCLES)). It is cleared on
//    every state entry and never exceeds the terminal count.
//  - SHOW: enabler_segment = ~(4'b0001<<idx) and sevent = hex(shadow[4*idx+:4]),
//    both valid in the first SHOW cycle. BLANK/IDLE: both all-ones.
//  - Frame boundary = the cycle of entry into SHOW with idx==0 (from IDLE or
//    BLANK). frame_start=1 there. If load_req==1 in the cycle before entry,
//    shadow<=value_in and load_ack=1 in the entry cycle. The new value is
//    displayed from that same slot. load_req is ignored at all other times.
//    The requester holds load_req until load_ack. Worst-case ack latency is
//    4*(REFRESH_DIV+BLANK_CYCLES) cycles.
//  - Simultaneous: load_req with enable falling -> no capture, no ack.
//  - Hex table (active-low): 0=1000000 1=1111001 2=0100100 3=0110000
//    4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000
//    b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
//  - lz_suppress=1: digit i>0 is blanked (sevent=1111111, enable still
//    asserted) if shadow[15:4*i]==0. Digit 0 is always shown.
//  - rst is dominant over enable and load_req in the same cycle.
// TESTING (bench params REFRESH_DIV=4, BLANK_CYCLES=2)
//  1 rst=0 2 cycles, enable=1 -> outputs all-ones, load_ack=0 during reset.
//    First SHOW begins 1 cycle after rst=1. Digit 0 shows '0' (1000000).
//  2 shadow=16'h1234, free-run 2 frames -> per 24-cycle frame: en 1110 x4
//    sevent=0011001('4'), 1111 x2, 1101 '3', 1111 x2, 1011 '2', 1111 x2,
//    0111 '1', 1111 x2, then wrap to 1110.
//  3 load_req=1 value_in=16'hBEEF raised during digit 2 SHOW -> no ack until
//    the next frame start. ack is exactly 1 cycle. Digit 0 then shows 'F'.
//    Old value 1234 is completed on digits 2,3 first.
//  4 lz_suppress=1, shadow=16'h00A5 -> digits 3,2 sevent=1111111, digit 1
//    'A' (0001000), digit 0 '5'. shadow=0000 -> only digit 0 lit '0'.
//  5 enable=0 mid-SHOW of digit 2 -> next cycle en=1111, seg=1111111.
//    enable=1 again -> restart at digit 0 with frame_start pulse.
//  6 rst=0 mid-BLANK with load_req=1 -> shadow=0, no ack. After release the
//    first frame start acks if load_req is still high.

Source files
------------

// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler
//   Drives one shared 7-segment bus across four digits. Each digit gets a SHOW
//   slot of REFRESH_DIV cycles, followed by a BLANK gap of BLANK_CYCLES cycles
//   with every digit off, which removes ghosting. The 16-bit display value is
//   held in a shadow register. That register only takes a new value at a frame
//   boundary, so a frame never mixes old and new digits.
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous reset, active low
//   enable           1 = scan, 0 = all digits off and FSM held idle
//   value_in[15:0]   candidate display value (4 hex nibbles)
//   load_req         level request to latch value_in at the next frame start
//   load_ack         1-cycle pulse in the cycle value_in is captured
//   lz_suppress      1 = blank leading-zero digits (digit 0 always shown)
//   enabler_segment  digit enables, active low, bit i = digit i
//   sevent[6:0]      segments {g,f,e,d,c,b,a}, active low
//   frame_start      1-cycle pulse when the digit 0 SHOW slot begins
//
// State table
//   S_IDLE  | scanning disabled, all outputs off
//   S_SHOW  | digit idx driven for REFRESH_DIV cycles
//   S_BLANK | all digits off for BLANK_CYCLES cycles, then next digit
module seg_scan_scheduler #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic        load_req,
  output logic        load_ack,
  input  logic        lz_suppress,
  output logic [3:0]  enabler_segment,
  output logic [6:0]  sevent,
  output logic        frame_start
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SHOW_TC  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             ack_q, ack_d;
  logic             fs_q, fs_d;
  logic [3:0]       en_q, en_d;
  logic [6:0]       seg_q, seg_d;

  logic [3:0]       nibble;
  logic [15:0]      upper;
  logic             lz_blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Next-state logic. Outputs are derived from the *next* state so that the
  // registered digit/segment values are already valid in the first SHOW cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    ack_d    = 1'b0;
    fs_d     = 1'b0;

    if (!enable) begin
      state_d = S_IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SHOW;
          idx_d   = 2'd0;
          cnt_d   = '0;
          fs_d    = 1'b1;
        end
        S_SHOW: begin
          if (cnt_q == SHOW_TC) begin
            state_d = S_BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_BLANK: begin
          if (cnt_q == BLANK_TC) begin
            state_d = S_SHOW;
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
            fs_d    = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end

    // Capture only at the frame boundary; the new value is shown in this slot.
    if (fs_d && load_req) begin
      shadow_d = value_in;
      ack_d    = 1'b1;
    end
  end

  always_comb begin
    nibble   = shadow_d[4*idx_d +: 4];
    upper    = shadow_d >> {idx_d, 2'b00};
    lz_blank = lz_suppress && (idx_d != 2'd0) && (upper == 16'h0000);

    en_d  = 4'b1111;
    seg_d = 7'b1111111;
    if (state_d == S_SHOW) begin
      en_d = ~(4'b0001 << idx_d);
      if (!lz_blank) begin
        seg_d = hex_to_seg(nibble);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      shadow_q <= 16'h0000;
      ack_q    <= 1'b0;
      fs_q     <= 1'b0;
      en_q     <= 4'b1111;
      seg_q    <= 7'b1111111;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ack_q    <= ack_d;
      fs_q     <= fs_d;
      en_q     <= en_d;
      seg_q    <= seg_d;
    end
  end

  assign load_ack        = ack_q;
  assign frame_start     = fs_q;
  assign enabler_segment = en_q;
  assign sevent          = seg_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// tb_seg_scan_scheduler
//   The reference model does not follow an FSM. It tracks the position inside a
//   24-cycle frame (4 digits x (4 SHOW + 2 BLANK)) and derives every output
//   from that position with plain arithmetic.
module tb_seg_scan_scheduler;

  localparam int RD    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = RD + BC;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] value_in;
  logic        load_req;
  logic        load_ack;
  logic        lz_suppress;
  logic [3:0]  enabler_segment;
  logic [6:0]  sevent;
  logic        frame_start;

  seg_scan_scheduler #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .value_in        (value_in),
    .load_req        (load_req),
    .load_ack        (load_ack),
    .lz_suppress     (lz_suppress),
    .enabler_segment (enabler_segment),
    .sevent          (sevent),
    .frame_start     (frame_start)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_run;
  int          m_pos;
  logic [15:0] m_shadow;
  bit          m_ack;
  bit          m_fs;
  logic [3:0]  e_en;
  logic [6:0]  e_seg;
  bit          auto_drop;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int d;
    int w;
    logic [15:0] up;
    if (!rst) begin
      m_run = 0; m_pos = 0; m_shadow = 16'h0; m_ack = 0; m_fs = 0;
    end else if (!enable) begin
      m_run = 0; m_pos = 0; m_ack = 0; m_fs = 0;
    end else begin
      if (!m_run) begin
        m_run = 1;
        m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
      end
      m_fs  = (m_pos == 0);
      m_ack = m_fs && load_req;
      if (m_ack) m_shadow = value_in;
    end
    e_en  = 4'hF;
    e_seg = 7'h7F;
    d = m_pos / SLOT;
    w = m_pos % SLOT;
    if (m_run && w < RD) begin
      e_en = ~(4'(1) << d);
      up   = m_shadow >> (4 * d);
      if (!(lz_suppress && d > 0 && up == 16'h0)) e_seg = hex_tab[up[3:0]];
    end
  endtask

  // One clock: model and DUT both sample the inputs at the edge, outputs are
  // compared 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_eq("digit_en", 32'(enabler_segment), 32'(e_en));
    check_eq("segments", 32'(sevent), 32'(e_seg));
    check_eq("load_ack", 32'(load_ack), 32'(m_ack));
    check_eq("frame_start", 32'(frame_start), 32'(m_fs));
    if (auto_drop && m_ack) load_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_to_pos(input int p);
    for (int i = 0; i < 3 * FRAME && !(m_run && m_pos == p); i++) cyc();
  endtask

  task automatic load_value(input logic [15:0] v);
    value_in = v;
    load_req = 1'b1;
    for (int i = 0; i < 2 * FRAME && load_req; i++) cyc();
    check_eq("load_done", 32'(load_req), 32'(0));
  endtask

  initial begin
    int lat;
    bit got_ack;
    rst = 1'b0; enable = 1'b1; value_in = 16'h0; load_req = 1'b0; lz_suppress = 1'b0;
    auto_drop = 1'b1;
    m_run = 0; m_pos = 0; m_shadow = 0; m_ack = 0; m_fs = 0; e_en = 4'hF; e_seg = 7'h7F;

    // reset with enable high: everything off, no ack
    run(2);
    check_eq("rst_en", 32'(enabler_segment), 32'hF);
    check_eq("rst_seg", 32'(sevent), 32'h7F);
    rst = 1'b1;
    cyc();
    check_eq("first_en", 32'(enabler_segment), 32'b1110);
    check_eq("first_seg", 32'(sevent), 32'b1000000);
    check_eq("first_fs", 32'(frame_start), 32'd1);

    // free-run frames with 1234
    load_value(16'h1234);
    run(2 * FRAME);

    // request raised during digit 2 SHOW; ack only at next frame start
    run_to_pos(2 * SLOT);
    value_in = 16'hBEEF;
    load_req = 1'b1;
    lat = 0;
    got_ack = 0;
    for (int i = 0; i < 4 * SLOT + 2 && !got_ack; i++) begin
      cyc();
      lat++;
      if (load_ack) got_ack = 1;
    end
    check_eq("beef_ack_seen", 32'(got_ack), 32'd1);
    check_eq("beef_ack_latency", 32'(lat), 32'(2 * SLOT));
    check_eq("beef_digit0", 32'(sevent), 32'b0001110);
    cyc();
    check_eq("ack_one_cycle", 32'(load_ack), 32'd0);
    run(FRAME);

    // leading-zero suppression
    lz_suppress = 1'b1;
    load_value(16'h00A5);
    run(FRAME);
    load_value(16'h0000);
    run(FRAME);
    lz_suppress = 1'b0;

    // enable drop in digit 2 SHOW, then restart
    run_to_pos(2 * SLOT + 1);
    enable = 1'b0;
    cyc();
    check_eq("dis_en", 32'(enabler_segment), 32'hF);
    check_eq("dis_seg", 32'(sevent), 32'h7F);
    run(3);
    enable = 1'b1;
    cyc();
    check_eq("reen_fs", 32'(frame_start), 32'd1);
    check_eq("reen_en", 32'(enabler_segment), 32'b1110);
    run(FRAME);

    // enable falling together with a request at the frame boundary
    run_to_pos(FRAME - 1);
    value_in = 16'h5A5A; load_req = 1'b1; enable = 1'b0;
    cyc();
    check_eq("drop_noack", 32'(load_ack), 32'd0);
    enable = 1'b1;
    run(FRAME + 2);

    // reset mid-BLANK with a pending request
    load_value(16'h9876);
    run_to_pos(SLOT + RD);
    value_in = 16'hC0DE; load_req = 1'b1;
    rst = 1'b0;
    cyc();
    check_eq("rst_noack", 32'(load_ack), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < FRAME + 2 && load_req; i++) cyc();
    check_eq("post_rst_ack", 32'(load_req), 32'd0);
    run(FRAME);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) rst = 1'b0; else rst = 1'b1;
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      if ($urandom_range(0, 19) == 0) lz_suppress = ~lz_suppress;
      if (!load_req && $urandom_range(0, 15) == 0) begin
        load_req = 1'b1;
        case ($urandom_range(0, 3))
          0:       value_in = 16'h0000;
          1:       value_in = 16'($urandom_range(0, 255));
          default: value_in = 16'($urandom);
        endcase
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
